// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the word-only single-port data RAM; sub-word stores use read-modify-write.
// Latency accept->resp_valid: LW/LB/LH 3, SW 2, SB/SH 4, any error 1 cycle.
// Backpressure: req_ready only in IDLE, one request in flight. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W.

`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module lsu_mem_ctrl #(
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter int unsigned RAM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_ena,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_wdata
);

   typedef enum logic [2:0] {IDLE, RD, LD, MRG, WR, DONE, ERR} state_t;

   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

   state_t      state;
   logic        store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;

   logic [31:0] req_rel;
   logic        range_err;
   logic        f3_bad;
   logic        mis_err;
   logic        req_err;
   logic [1:0]  req_off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] merge;

   assign req_ready = (state == IDLE);

   // Classify the incoming request: legality, range, alignment and effective lane offset.
   always_comb begin
      req_rel   = req_addr - RAM_BASE;
      range_err = ({1'b0, req_rel} >= RAM_BYTES);
      if (req_store)
         f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      mis_err = 1'b0;
      req_off = req_addr[1:0];
      case (req_funct3[1:0])
         2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
            mis_err = req_addr[0];
`else
            req_off = {req_addr[1], 1'b0};
`endif
         end
         2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
            mis_err = (req_addr[1:0] != 2'b00);
`else
            req_off = 2'b00;
`endif
         end
         default: ;
      endcase
      req_err = f3_bad | range_err | mis_err;
   end

   // Lane extraction for loads and lane merge for sub-word stores, both off the returning read data.
   always_comb begin
      case (off_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = mem_rdata;
      endcase
      merge = mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         case (off_q)
            2'd0:    merge[7:0]   = wdata_q[7:0];
            2'd1:    merge[15:8]  = wdata_q[7:0];
            2'd2:    merge[23:16] = wdata_q[7:0];
            default: merge[31:24] = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merge[31:16] = wdata_q[15:0];
      end else begin
         merge[15:0] = wdata_q[15:0];
      end
   end

   // Request FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         mem_ena    <= 1'b0;
         mem_rw     <= `MEM_READ;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         store_q    <= 1'b0;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         wdata_q    <= 32'h0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         mem_ena    <= 1'b0;
         mem_rw     <= `MEM_READ;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  store_q  <= req_store;
                  funct3_q <= req_funct3;
                  off_q    <= req_off;
                  wdata_q  <= req_wdata;
                  if (req_err) begin
                     state      <= ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     mem_ena  <= 1'b1;
                     mem_addr <= {req_rel[31:2], 2'b00};
                     if (!req_store || req_funct3[1:0] != 2'b10) begin
                        state <= RD;
                     end else begin
                        state     <= WR;
                        mem_rw    <= `MEM_WRITE;
                        mem_wdata <= req_wdata;
                     end
                  end
               end
            end
            RD:  state <= store_q ? MRG : LD;
            LD: begin
               resp_rdata <= ld_data;
               resp_valid <= 1'b1;
               state      <= DONE;
            end
            MRG: begin
               mem_wdata <= merge;
               mem_ena   <= 1'b1;
               mem_rw    <= `MEM_WRITE;
               state     <= WR;
            end
            WR: begin
               resp_rdata <= 32'h0;
               resp_valid <= 1'b1;
               state      <= DONE;
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: behavioural RAM, vector table feeding a response scoreboard,
// plus hand sequences for strobe timing, error no-access, back-to-back and reset mid-RMW.
`timescale 1ns/1ps
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module tb_lsu_mem_ctrl;
   localparam int RAM_WORDS = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_ena;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.RAM_BASE(32'h0), .RAM_WORDS(RAM_WORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_wdata(mem_wdata)
   );

   typedef struct {
      logic        store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   typedef struct {
      int          id;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   int   n_neg = 0;
   int   strobe_count = 0;
   int   wr_count = 0;
   int   resp_count = 0;
   logic prev_rv = 1'b0;
   logic ram_clr = 1'b1;
   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_log[$];
   vec_t vecs[$];

   logic [31:0] ram [RAM_WORDS];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // RAM with one-cycle read latency, no byte enables
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 32'h0;
         mem_rdata <= 32'h0;
      end else if (mem_ena) begin
         if (mem_rw == `MEM_WRITE) ram[mem_addr[13:2]] <= mem_wdata;
         else mem_rdata <= ram[mem_addr[13:2]];
      end
   end

   // Monitor: logs accepts and strobes, pops the scoreboard on each response
   always @(negedge clk) begin
      exp_t e;
      int   a;
      n_neg++;
      if (!rst_n) begin
         acc_q.delete();
         prev_rv = 1'b0;
      end else begin
         if (mem_ena) strobe_count++;
         if (mem_ena && mem_rw == `MEM_WRITE) wr_count++;
         if (req_valid && req_ready) begin
            acc_q.push_back(n_neg);
            acc_log.push_back(n_neg);
         end
         if (resp_valid) begin
            resp_count++;
            chk("resp_valid_consecutive", {31'h0, prev_rv}, 32'h0);
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: got resp_valid=1 at negedge %0d, expected no response", n_neg);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk($sformatf("req%0d_err", e.id), {31'h0, resp_err}, {31'h0, e.err});
               chk($sformatf("req%0d_rdata", e.id), resp_rdata, e.rdata);
               chk($sformatf("req%0d_latency", e.id), 32'(n_neg - a), 32'(e.lat));
            end
         end
         prev_rv = resp_valid;
      end
   end

   task automatic push_exp(input int id, input logic err, input logic [31:0] rd, input int lat);
      exp_t e;
      e.id = id; e.err = err; e.rdata = rd; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic err, input logic [31:0] rd, input int lat);
      vec_t v;
      v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.err = err; v.rdata = rd; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Present a request and hold it until accepted; called and returns at posedge+1
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep);
      int k;
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      k = 0;
      while (!req_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (!req_ready) begin
         tests++;
         fails++;
         $display("FAIL req_accept_timeout: req_ready=0 after %0d cycles, expected 1", k);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk(name, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      int wc, sc, rc, n0;
      repeat (3) @(posedge clk);
      #1;
      ram_clr = 1'b0;
      chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
      chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("reset_resp_err", {31'h0, resp_err}, 32'h0);
      chk("reset_resp_rdata", resp_rdata, 32'h0);
      chk("reset_mem_ena", {31'h0, mem_ena}, 32'h0);
      chk("reset_mem_rw", {31'h0, mem_rw}, {31'h0, `MEM_READ});
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // SW: write strobe in the first cycle after accept
      push_exp(100, 1'b0, 32'h0, 2);
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      chk("sw_strobe_ena", {31'h0, mem_ena}, 32'h1);
      chk("sw_strobe_rw", {31'h0, mem_rw}, {31'h0, `MEM_WRITE});
      chk("sw_strobe_addr", mem_addr, 32'h10);
      chk("sw_strobe_wdata", mem_wdata, 32'hDEADBEEF);
      drain("sw_drain");

      //  store  f3      addr          wdata          err   rdata          lat
      add(1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 3);
      add(1'b1, 3'b010, 32'h10,   32'h11223344, 1'b0, 32'h0,        2);
      add(1'b1, 3'b000, 32'h12,   32'h000000AB, 1'b0, 32'h0,        4);
      add(1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h11AB3344, 3);
      add(1'b0, 3'b000, 32'h12,   32'h0,        1'b0, 32'hFFFFFFAB, 3);
      add(1'b0, 3'b100, 32'h12,   32'h0,        1'b0, 32'h000000AB, 3);
      add(1'b1, 3'b001, 32'h16,   32'h00008001, 1'b0, 32'h0,        4);
      add(1'b0, 3'b010, 32'h14,   32'h0,        1'b0, 32'h80010000, 3);
      add(1'b0, 3'b001, 32'h16,   32'h0,        1'b0, 32'hFFFF8001, 3);
      add(1'b0, 3'b101, 32'h16,   32'h0,        1'b0, 32'h00008001, 3);
      add(1'b0, 3'b010, 32'h4000, 32'h0,        1'b1, 32'h0,        1);
      add(1'b0, 3'b011, 32'h0,    32'h0,        1'b1, 32'h0,        1);
      add(1'b1, 3'b100, 32'h0,    32'h0,        1'b1, 32'h0,        1);
`ifdef LSU_MISALIGN_TRAP_EN
      add(1'b0, 3'b001, 32'h11,   32'h0,        1'b1, 32'h0,        1);
`else
      add(1'b0, 3'b001, 32'h11,   32'h0,        1'b0, 32'h00003344, 3);
`endif
      add(1'b0, 3'b000, 32'h13,   32'h0,        1'b0, 32'h00000011, 3);
      add(1'b0, 3'b000, 32'h10,   32'h0,        1'b0, 32'h00000044, 3);
      add(1'b0, 3'b001, 32'h12,   32'h0,        1'b0, 32'h000011AB, 3);
      add(1'b0, 3'b010, 32'h3FFC, 32'h0,        1'b0, 32'h0,        3);
      add(1'b1, 3'b000, 32'h3FFF, 32'h00000080, 1'b0, 32'h0,        4);
      add(1'b0, 3'b000, 32'h3FFF, 32'h0,        1'b0, 32'hFFFFFF80, 3);
      add(1'b0, 3'b010, 32'h3FFC, 32'h0,        1'b0, 32'h80000000, 3);
`ifdef LSU_MISALIGN_TRAP_EN
      add(1'b1, 3'b010, 32'h1A,   32'hCAFEF00D, 1'b1, 32'h0,        1);
      add(1'b0, 3'b010, 32'h18,   32'h0,        1'b0, 32'h0,        3);
`else
      add(1'b1, 3'b010, 32'h1A,   32'hCAFEF00D, 1'b0, 32'h0,        2);
      add(1'b0, 3'b010, 32'h18,   32'h0,        1'b0, 32'hCAFEF00D, 3);
`endif
      add(1'b0, 3'b110, 32'h0,    32'h0,        1'b1, 32'h0,        1);
      add(1'b0, 3'b001, 32'h14,   32'h0,        1'b0, 32'h0,        3);
      add(1'b1, 3'b000, 32'h11,   32'hFFFFFF7F, 1'b0, 32'h0,        4);
      add(1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h11AB7F44, 3);

      foreach (vecs[i]) begin
         push_exp(i, vecs[i].err, vecs[i].rdata, vecs[i].lat);
         do_req(vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0);
      end
      drain("table_drain");

      // Out-of-range load never touches the RAM
      sc = strobe_count;
      push_exp(200, 1'b1, 32'h0, 1);
      do_req(1'b0, 3'b010, 32'(RAM_WORDS * 4), 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      drain("range_drain");
      chk("range_no_strobe", 32'(strobe_count - sc), 32'h0);

      // Back-to-back loads with req_valid held high
      n0 = acc_log.size();
      rc = resp_count;
      push_exp(300, 1'b0, 32'h11AB7F44, 3);
      push_exp(301, 1'b0, 32'h80010000, 3);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
      do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
      drain("b2b_drain");
      chk("b2b_accept_count", 32'(acc_log.size() - n0), 32'h2);
      if (acc_log.size() - n0 == 2)
         chk("b2b_accept_gap", 32'(acc_log[n0 + 1] - acc_log[n0]), 32'h4);
      chk("b2b_resp_count", 32'(resp_count - rc), 32'h2);

      // Reset asserted during the merge cycle of a byte store
      push_exp(400, 1'b0, 32'h0, 2);
      do_req(1'b1, 3'b010, 32'h20, 32'h01020304, 1'b0);
      drain("rst_setup_drain");
      wc = wr_count;
      sc = strobe_count;
      rc = resp_count;
      do_req(1'b1, 3'b000, 32'h22, 32'h00000055, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mem_ena", {31'h0, mem_ena}, 32'h0);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid_after", {31'h0, resp_valid}, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_write", 32'(wr_count - wc), 32'h0);
      chk("rst_one_read_strobe", 32'(strobe_count - sc), 32'h1);
      chk("rst_no_resp", 32'(resp_count - rc), 32'h0);
      chk("rst_ram_unchanged", ram[8], 32'h01020304);
      push_exp(401, 1'b0, 32'h01020304, 3);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
      drain("rst_reload_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator on the data-memory port of the word-only, single-port RAM.
- Accepts one load/store request at a time from the MEM stage.
- Drives mem_ena/mem_rw/mem_addr/mem_wdata and extracts sub-word results from mem_rdata, which has 1-cycle read latency.
- Byte/halfword stores use read-modify-write because the RAM has no byte enables.

Parameters:
RAM_BASE, 32'h0000_0000, byte address of RAM word 0
RAM_WORDS, 4096, RAM depth in 32-bit words; accesses at or beyond RAM_BASE+4*RAM_WORDS are errors

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, LSBs used for B/H
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; misaligned, out of range, or illegal funct3
resp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors
mem_ena  out  1  RAM access strobe
mem_rw  out  1  `MEM_READ / `MEM_WRITE from common.v
mem_addr  out  32  word-aligned RAM address (addr-RAM_BASE, bits[1:0]=0)
mem_rdata  in  32  RAM read data, valid the cycle after a read strobe
mem_wdata  out  32  RAM write data

Behaviour:
- Reset values: state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_ena=0, mem_rw=`MEM_READ, mem_addr=0, mem_wdata=0.
- Request capture: req_ready=1 only in IDLE. On accept, latch store, funct3, addr, wdata, and offset off=addr[1:0].
- mem_* outputs: decoded from state and latched registers. mem_ena is 1 only in states RD and WR.
- States and transitions:
  - IDLE: accept → ERR if error check fails; else RD for any load or SB/SH; else WR for SW.
  - RD: mem_ena=1, mem_rw=READ → LD (load) or MRG (store).
  - LD: mem_rdata valid. Select byte off or halfword off[1], extend per funct3, register into resp_rdata → DONE.
  - MRG: merge req_wdata[7:0] into byte lane off, or req_wdata[15:0] into halfword lane off[1], of mem_rdata. Other lanes unchanged. Register result as mem_wdata → WR.
  - WR: mem_ena=1, mem_rw=WRITE; for SW, mem_wdata=req_wdata → DONE.
  - ERR, DONE: both pulse resp_valid for 1 cycle and return to IDLE in the same cycle.
- req_ready timing: goes to 1 the cycle after DONE/ERR. No overlap between requests.
- Latency, accept edge to resp_valid cycle: LW/LB/LH 3, SW 2, SB/SH 4, error 1.
- Error checks:
  - Illegal funct3: load 011/110/111; store other than 000/001/010.
  - Range: (addr-RAM_BASE) >= 4*RAM_WORDS, unsigned.
  - Misalignment, per the optional feature.
  - On error: no memory access, resp_err=1, resp_rdata=0.
- Sign extension: LB takes data bit 7, LH bit 15; BU/HU zero-fill.
- Stores: resp_rdata=0.
- Reset mid-operation: rst_n low at an edge forces IDLE regardless of state.
  - A WR-state write presented at that same edge is committed by the RAM; this is allowed.
  - No partial merge is written after reset.
  - resp_valid=0 the following cycle.
- resp_valid is never asserted in two consecutive cycles.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: H with addr[0]=1, or W with addr[1:0]≠0, is an error. Behaves as ERR: resp_err=1, no access.
- Undefined: no misalignment error. Offset bits are masked:
  - H uses off={addr[1],1'b0}.
  - W uses off=0.
  - Access proceeds as aligned-down.

Test Plan:
- Word round-trip: SW addr 0x10 data 0xDEADBEEF → WR strobe at cycle 1 with mem_addr 0x10, resp at cycle 2. Then LW 0x10 → resp_rdata 0xDEADBEEF at cycle 3, resp_err=0.
- Byte RMW: word 0x10=0x11223344; SB 0x12 data 0xAB → read, then write 0x11AB3344. LB 0x12 → 0xFFFFFFAB; LBU 0x12 → 0x000000AB.
- Halfword: SH 0x16 data 0x8001 over 0 → word 0x80010000. LH 0x16 → 0xFFFF8001; LHU → 0x00008001.
- Errors:
  - LW 0x4*RAM_WORDS → resp_err=1 next cycle, mem_ena never 1.
  - funct3 011 load → resp_err=1.
  - With LSU_MISALIGN_TRAP_EN, LH 0x11 → resp_err=1. Without it, LH 0x11 returns the halfword at 0x10.
- Reset mid-RMW: SB issued, rst_n low in MRG cycle → no WR strobe, resp_valid stays 0, req_ready=1 after release. Memory word unchanged.
- Back-to-back: req_valid held high with two LW → second accepted the cycle after first resp_valid. Exactly one resp_valid per request.
